main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm_pkg.sv | 48 ++++
 rtl/main_control_fsm.sv | 174 +++++++++++++++++
 tb/tb_main_control_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_pkg.sv
// Shared processor package: control-FSM state enumeration, opcode constants
// (instruction[15:12]), ALUOp encodings and datapath mux-select codes. The
// ALU control decoder also imports this package.
//
// Optional feature macro: CTRL_JUMP_EN. When it is defined, the JUMP state
// exists and opcode 0111 is a legal jump.
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    RWB,
    BRANCH
`ifdef CTRL_JUMP_EN
    , JUMP
`endif
  } ctrl_state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_J     = 4'b0111;

  // 2'b11 is never produced by the main control.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  // ALU operand B selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle processor main control FSM.
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous active-high reset
//   opcode[3:0]   instruction[15:12], sampled in DECODE (held by the IR after)
//   mem_ready     memory access completes this cycle
//   ALUOp[1:0]    00 add, 01 subtract, 10 R-type funct decode
//   alu_src_a, alu_src_b[1:0], pc_source[1:0]  datapath mux selects
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_write, reg_dst             datapath strobes/selects
//   illegal_op    one-cycle pulse in DECODE on an undecodable opcode
//   instr_count   retired-instruction counter (wraps at 16 bits)
//
// Optional feature macro: CTRL_JUMP_EN (enables the JUMP state / opcode 0111).
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALUOp,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        illegal_op,
  output logic [15:0] instr_count
);

  ctrl_state_t state, next_state;
  aluop_t      aluop;
  logic        retire;
  logic [15:0] instr_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FETCH;
      instr_count_q <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count_q <= instr_count_q + 16'd1;
    end
  end

  assign instr_count = instr_count_q;
  assign ALUOp       = aluop;

  always_comb begin
    next_state    = state;
    retire        = 1'b0;
    aluop         = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    illegal_op    = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
`ifdef CTRL_JUMP_EN
          OP_J:         next_state = JUMP;
`endif
          default: begin
            next_state = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = FETCH;
        retire     = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          next_state = FETCH;
          retire     = 1'b1;
        end
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        aluop      = ALU_FUNCT;
        next_state = RWB;
      end
      RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        next_state    = FETCH;
        retire        = 1'b1;
      end
`ifdef CTRL_JUMP_EN
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        next_state = FETCH;
        retire     = 1'b1;
      end
`endif
      default: next_state = FETCH;
    endcase

    // While reset is held the datapath sees the FETCH decode with the PC/IR
    // strobes suppressed, whatever state the register still holds.
    if (reset) begin
      aluop         = ALU_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_FOUR;
      pc_source     = PCSRC_ALU;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b1;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm. Each instruction is expanded
// into its sequence of phases from the instruction-class rules; each phase
// carries its expected control vector. Retired-instruction count is kept as
// a plain 16-bit integer.
module tb_main_control_fsm;

  logic        clock;
  logic        reset;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_write, reg_dst, illegal_op;
  logic [15:0] instr_count;

  main_control_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pcsrc;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, ill;
  } ctl_t;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_ILLEGAL, P_MEMADR, P_MEMRD,
                P_MEMWB, P_MEMWR, P_EXEC, P_RWB, P_BRANCH, P_JUMP} ph_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] model_count = 16'd0;
  bit          jump_en;

  function automatic ctl_t expect_for(ph_t ph, logic rdy);
    ctl_t e = '0;
    case (ph)
      P_RESET:   begin e.mrd = 1'b1; e.src_b = 2'b01; end
      P_FETCH:   begin e.mrd = 1'b1; e.src_b = 2'b01; e.irw = rdy; e.pcw = rdy; end
      P_DECODE:  e.src_b = 2'b11;
      P_ILLEGAL: begin e.src_b = 2'b11; e.ill = 1'b1; end
      P_MEMADR:  begin e.src_a = 1'b1; e.src_b = 2'b10; end
      P_MEMRD:   begin e.mrd = 1'b1; e.iord = 1'b1; end
      P_MEMWB:   begin e.rw = 1'b1; e.m2r = 1'b1; end
      P_MEMWR:   begin e.mwr = 1'b1; e.iord = 1'b1; end
      P_EXEC:    begin e.src_a = 1'b1; e.aluop = 2'b10; end
      P_RWB:     begin e.rw = 1'b1; e.rdst = 1'b1; end
      P_BRANCH:  begin e.src_a = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
      P_JUMP:    begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic bit is_legal(logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0100) || (op == 4'b0101) ||
           (op == 4'b0110) || (jump_en && op == 4'b0111);
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then return 1 time unit after the next rising edge.
  task automatic cycle(input ph_t ph, input logic rdy, input logic [3:0] op);
    ctl_t obs, exp;
    opcode    = op;
    mem_ready = rdy;
    @(negedge clock);
    exp = expect_for(ph, rdy);
    obs = {ALUOp, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
           i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
           reg_dst, illegal_op};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL ctl_%s obs=%h exp=%h", ph.name(), obs, exp);
    end
    vectors++;
    assert (!(mem_read && mem_write)) else begin
      miscompares++;
      $error("FAIL rd_wr_excl_%s mem_read=%b mem_write=%b exp=not_both", ph.name(), mem_read, mem_write);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_count(input string tag);
    vectors++;
    assert (instr_count === model_count) else begin
      miscompares++;
      $error("FAIL count_%s obs=%h exp=%h", tag, instr_count, model_count);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int unsigned fs, input int unsigned ms);
    for (int unsigned i = 0; i < fs; i++) cycle(P_FETCH, 1'b0, 4'($urandom));
    cycle(P_FETCH, 1'b1, 4'($urandom));
    if (!is_legal(op)) begin
      cycle(P_ILLEGAL, 1'($urandom), op);
    end else begin
      cycle(P_DECODE, 1'($urandom), op);
      case (op)
        4'b0000: begin
          cycle(P_EXEC, 1'($urandom), op);
          cycle(P_RWB, 1'($urandom), op);
        end
        4'b0100: begin
          cycle(P_MEMADR, 1'($urandom), op);
          for (int unsigned i = 0; i < ms; i++) cycle(P_MEMRD, 1'b0, op);
          cycle(P_MEMRD, 1'b1, op);
          cycle(P_MEMWB, 1'($urandom), op);
        end
        4'b0101: begin
          cycle(P_MEMADR, 1'($urandom), op);
          for (int unsigned i = 0; i < ms; i++) cycle(P_MEMWR, 1'b0, op);
          cycle(P_MEMWR, 1'b1, op);
        end
        4'b0110: cycle(P_BRANCH, 1'($urandom), op);
        default: cycle(P_JUMP, 1'($urandom), op);
      endcase
      model_count = model_count + 16'd1;
    end
    check_count($sformatf("op%b", op));
  endtask

  initial begin
`ifdef CTRL_JUMP_EN
    jump_en = 1'b1;
`else
    jump_en = 1'b0;
`endif
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 4'b0000;

    // Reset held for two cycles, then the first cycle after it
    cycle(P_RESET, 1'b0, 4'b0000);
    cycle(P_RESET, 1'b0, 4'b0000);
    reset = 1'b0;
    check_count("after_reset");

    // Directed instruction classes
    run_instr(4'b0000, 0, 0);   // R-type, count becomes 1
    run_instr(4'b0100, 0, 2);   // LW with two memory stalls
    run_instr(4'b0101, 1, 1);   // SW with fetch and write stalls
    run_instr(4'b0110, 0, 0);   // BEQ
    run_instr(4'b1111, 0, 0);   // illegal
    run_instr(4'b0111, 0, 0);   // J (legal only with the jump feature)
    run_instr(4'b0100, 2, 0);

    // Reset during a MEMWR stall
    cycle(P_FETCH, 1'b1, 4'b0000);
    cycle(P_DECODE, 1'b1, 4'b0101);
    cycle(P_MEMADR, 1'b0, 4'b0101);
    cycle(P_MEMWR, 1'b0, 4'b0101);
    reset = 1'b1;
    cycle(P_RESET, 1'b0, 4'b0101);
    reset = 1'b0;
    model_count = 16'd0;
    check_count("reset_in_memwr");
    run_instr(4'b0000, 0, 0);

    // Randomised instruction stream
    for (int unsigned n = 0; n < 150; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 5))
        0: op = 4'b0000;
        1: op = 4'b0100;
        2: op = 4'b0101;
        3: op = 4'b0110;
        4: op = 4'b0111;
        default: op = 4'($urandom);
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Counter wrap: stand in for 65535 retirements, then retire one more
    force dut.instr_count_q = 16'hFFFF;
    #1;
    release dut.instr_count_q;
    model_count = 16'hFFFF;
    run_instr(4'b0000, 0, 0);
    vectors++;
    assert (instr_count === 16'h0000) else begin
      miscompares++;
      $error("FAIL count_wrap obs=%h exp=0000", instr_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
